// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Loads a program into the CPU's 16-bit instruction memory from a byte
//   stream. It drives the write side of the instruction memory. The CPU is
//   held in reset until a frame has been loaded and its checksum matches.
//
//   Frame: LEN_HI, LEN_LO, LEN words (high byte first), CSUM.
//   CSUM is the XOR of every payload byte. The length bytes are not part
//   of the checksum.
//
// Parameters
//   ADDR_WIDTH  instruction memory address width
//   BASE_ADDR   address that receives the first word of a frame
//   MAX_WORDS   largest LEN accepted; a larger LEN faults the load
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-low reset
//   load_start  one-cycle pulse that arms a load (ignored while busy)
//   in_data     stream byte; transfers when in_valid & in_ready
//   in_valid    in_data is valid this cycle
//   in_ready    loader accepts a byte this cycle
//   mem_addr    instruction memory write address
//   mem_data    instruction memory write data
//   mem_we      one-cycle write strobe
//   cpu_hold    holds the CPU in reset while high
//   busy        a load is in progress
//   done        last load succeeded (level)
//   error       last load failed (level)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    // Size of the address space, kept wide so BASE_ADDR+LEN cannot wrap.
    localparam logic [63:0] SPAN = 64'd1 << ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q,   len_d;
    logic [7:0]              hi_q,    hi_d;
    logic [15:0]             cnt_q,   cnt_d;
    logic [7:0]              csum_q,  csum_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [15:0]             data_q,  data_d;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] cnt_inc;
    logic [63:0] end_addr;
    logic        len_fault;

    // Output decode: every status output is a pure function of the state,
    // so an async reset returns all of them to their reset values at once.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            S_IDLE:   busy = 1'b0;
            S_LEN_HI,
            S_LEN_LO,
            S_DATA_HI,
            S_DATA_LO,
            S_CSUM:   in_ready = 1'b1;
            S_WRITE:  mem_we = 1'b1;
            S_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr = addr_q;
    assign mem_data = data_q;

    assign xfer     = in_valid & in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign cnt_inc  = 16'(cnt_q + 16'd1);
    assign end_addr = 64'(BASE_ADDR) + 64'(len_full);
    // Too many words, or the frame would run past the top of memory.
    assign len_fault = (32'(len_full) > MAX_WORDS) || (end_addr > SPAN);

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d = S_LEN_HI;
                    cnt_d   = '0;
                    csum_d  = '0;
                    addr_d  = BASE;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else if (len_fault) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    data_d  = {hi_q, in_data};
                    csum_d  = csum_q ^ in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The strobe is up for this one cycle; the address and count
                // advance so the next word lands at BASE_ADDR+k.
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Frames are turned into expected
//   memory writes and an expected pass/fail result by a frame-level model;
//   a compare process checks every write strobe against that list.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int unsigned AW   = 16;
    localparam int unsigned BASE = 0;
    localparam int unsigned MAXW = 1024;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    program_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_start(load_start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected writes {addr, data}, and the log of observed writes.
    logic [31:0] exp_q[$];
    logic [15:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Compare process: every write strobe must match the next expected write.
    always @(negedge clock) begin
        if (reset && mem_we) begin
            obs_addr.push_back(16'(mem_addr));
            obs_data.push_back(mem_data);
            obs_cyc.push_back(cyc);
            check("we_with_ready", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_write: got %h@%h expected no write", mem_data, mem_addr);
            end else begin
                check("write", {16'(mem_addr), mem_data}, exp_q.pop_front());
            end
        end
    end

    // Frame-level model: decides how many bytes the loader will consume,
    // which writes it must issue, and whether the load must succeed.
    function automatic void model_frame(input logic [7:0] f[$], output int n_used, output bit ok);
        int unsigned len;
        logic [7:0]  x;
        len = {f[0], f[1]};
        if (len > MAXW || BASE + len > (1 << AW)) begin
            n_used = 2;
            ok     = 1'b0;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < int'(len); k++) begin
            x = x ^ f[2 + 2*k] ^ f[3 + 2*k];
            exp_q.push_back({16'(BASE + k), f[2 + 2*k], f[3 + 2*k]});
        end
        n_used = 2 + 2 * int'(len) + 1;
        ok     = (f[n_used - 1] == x);
    endfunction

    // Drives one frame. gap is the percent chance of an idle cycle before a
    // byte (with stray load_start pulses that must be ignored). When
    // stop_after >= 0 the frame is abandoned once that many writes occurred.
    // Returns at the falling edge after the last accepted byte.
    task automatic send_frame(input logic [7:0] f[$], input int n, input int gap, input int stop_after);
        int wd;
        int g;
        @(negedge clock);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        check("armed_busy", {31'b0, busy}, 32'd1);
        check("armed_flags", {29'b0, done, error, cpu_hold}, 32'b001);
        for (int i = 0; i < n; i++) begin
            if (stop_after >= 0 && obs_data.size() >= stop_after) begin
                in_valid = 1'b0;
                return;
            end
            g = 0;
            while (g < 10 && $urandom_range(99) < gap) begin
                in_valid   = 1'b0;
                in_data    = 8'($urandom);
                load_start = ($urandom_range(3) == 0);
                @(negedge clock);
                load_start = 1'b0;
                g++;
            end
            in_valid = 1'b1;
            in_data  = f[i];
            wd = 0;
            while (!in_ready && wd < 40) begin
                @(negedge clock);
                wd++;
            end
            if (!in_ready) begin
                check("byte_timeout", 32'(i), 32'hFFFF_FFFF);
                in_valid = 1'b0;
                return;
            end
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int gap);
        int n;
        bit ok;
        exp_q.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        model_frame(f, n, ok);
        send_frame(f, n, gap, -1);
        check("res_done", {31'b0, done}, {31'b0, ok});
        check("res_error", {31'b0, error}, {31'b0, !ok});
        check("res_hold", {31'b0, cpu_hold}, {31'b0, !ok});
        check("res_busy", {31'b0, busy}, 32'd0);
        check("res_missing_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, {26'b0, in_ready, mem_we, cpu_hold, busy, done, error}, 32'b001000);
        check({tag, "_addr"}, 32'(mem_addr), 32'(BASE));
        check({tag, "_data"}, 32'(mem_data), 32'd0);
    endtask

    initial begin
        logic [7:0] f1[$];
        logic [7:0] fr[$];
        logic [7:0] x;
        int         len;

        f1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};

        #3;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b1;

        // 1: saturated frame, literal expectations pin the model.
        run_frame(f1, 0);
        check("t1_count", 32'(obs_data.size()), 32'd2);
        if (obs_data.size() == 2) begin
            check("t1_w0", {obs_addr[0], obs_data[0]}, 32'h0000_1234);
            check("t1_w1", {obs_addr[1], obs_data[1]}, 32'h0001_ABCD);
            check("t1_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd3);
        end

        // 2: bad checksum.
        fr = f1;
        fr[6] = 8'h41;
        run_frame(fr, 0);
        check("t2_count", 32'(obs_data.size()), 32'd2);
        check("t2_flags", {29'b0, done, error, cpu_hold}, 32'b011);

        // 3: empty frame.
        fr = '{8'h00, 8'h00, 8'h00};
        run_frame(fr, 0);
        check("t3_count", 32'(obs_data.size()), 32'd0);
        check("t3_done", {31'b0, done}, 32'd1);

        // 4: LEN one above the limit.
        fr = '{8'h04, 8'h01};
        run_frame(fr, 0);
        check("t4_count", 32'(obs_data.size()), 32'd0);
        check("t4_error", {31'b0, error}, 32'd1);

        // 5: frame 1 with gaps and stray load_start pulses.
        for (int r = 0; r < 4; r++) begin
            run_frame(f1, 40);
            check("t5_count", 32'(obs_data.size()), 32'd2);
            if (obs_data.size() == 2) begin
                check("t5_w0", {obs_addr[0], obs_data[0]}, 32'h0000_1234);
                check("t5_w1", {obs_addr[1], obs_data[1]}, 32'h0001_ABCD);
            end
        end

        // 6: reset after the first write, then a clean reload.
        exp_q.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        begin
            int n;
            bit ok;
            model_frame(f1, n, ok);
            send_frame(f1, n, 0, 1);
        end
        check("t6_first_write", 32'(obs_data.size()), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("t6_abort");
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        run_frame(f1, 0);
        check("t6_reload_count", 32'(obs_data.size()), 32'd2);

        // Largest legal frame.
        fr = '{8'h04, 8'h00};
        x  = 8'h00;
        for (int k = 0; k < 2 * int'(MAXW); k++) begin
            fr.push_back(8'($urandom));
            x = x ^ fr[fr.size() - 1];
        end
        fr.push_back(x);
        run_frame(fr, 0);
        check("max_count", 32'(obs_data.size()), MAXW);

        // Random frames: lengths, payloads, checksums and gaps.
        for (int t = 0; t < 40; t++) begin
            fr.delete();
            if ($urandom_range(7) == 0) begin
                len = $urandom_range(65535, MAXW + 1);
            end else begin
                len = $urandom_range(6, 0);
            end
            fr.push_back(8'(len >> 8));
            fr.push_back(8'(len));
            x = 8'h00;
            if (len <= int'(MAXW)) begin
                for (int k = 0; k < 2 * len; k++) begin
                    fr.push_back(8'($urandom));
                    x = x ^ fr[fr.size() - 1];
                end
                if ($urandom_range(3) == 0) begin
                    x = x ^ 8'($urandom_range(255, 1));
                end
                fr.push_back(x);
            end
            run_frame(fr, $urandom_range(50, 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
